keypad_code_lock: RTL and testbench
===================================

// Module: keypad_code_lock
// PURPOSE
//   Downstream consumer of the keypad scanner's 4-bit key code. Collects digit
//   presses into a CODE_LEN-digit entry buffer and compares it with a stored code.
//   Drives unlock, error and lockout status, and exposes the last accepted key so
//   the 7-segment decoder can show it. Owner can reprogram the code while unlocked.
// PARAMETERS
//   CODE_LEN       4        digits per code (1..8)
//   DEFAULT_CODE   32'h1234 reset code, low CODE_LEN nibbles used, first digit most significant
//   MAX_FAILS      3        consecutive failed attempts that trigger lockout (>=1)
//   UNLOCK_CYCLES  500      cycles the lock stays open before auto-relock (>=1)
//   LOCKOUT_CYCLES 1000     cycles all keys are ignored after MAX_FAILS (>=1)
// PORTS
//   clk          in   1             system clock
//   rst_n        in   1             reset, asynchronous assert, active low
//   key          in   4             key code: 0x0-0x9 digit, 0xA prog, 0xE clear(*), 0xF enter(#)
//   key_valid    in   1             1-cycle strobe, key is sampled only when high
//   unlocked     out  1             high while in OPEN
//   prog_mode    out  1             high while in PROGRAM
//   error        out  1             1-cycle pulse on each failed attempt
//   locked_out   out  1             high while in LOCKOUT
//   digit_count  out  $clog2(CODE_LEN+1)  digits currently buffered
//   disp_key     out  4             last accepted key code, for the decoder
// BEHAVIOUR
//   Reset: state=ENTRY, buffer=0, digit_count=0, fail_cnt=0, timers=0,
//     code=DEFAULT_CODE, disp_key=0, all status outputs 0. Reset mid-operation
//     discards any programmed code.
//   Keys are acted on only in the cycle where key_valid=1. key is ignored otherwise.
//   Accepted keys update disp_key on the next edge. Ignored keys leave it unchanged.
//   ENTRY:
//     - Digit with count<CODE_LEN: shift in at the LS nibble, count+1.
//     - Digit with count==CODE_LEN: ignored.
//     - 0xE: clear buffer, count=0.
//     - 0xF with count==CODE_LEN: compare combinationally.
//       Match -> OPEN, fail_cnt=0. Mismatch -> FAIL.
//     - 0xF with count<CODE_LEN: -> FAIL.
//     - 0xA-0xD: ignored.
//   Latency: unlocked rises or error pulses on the edge after the 0xF strobe.
//   FAIL (1 cycle, error=1): fail_cnt+1.
//     If the new count equals MAX_FAILS -> LOCKOUT. Otherwise -> ENTRY.
//     Buffer is cleared.
//   LOCKOUT: all keys ignored. Timer counts LOCKOUT_CYCLES.
//     At expiry -> ENTRY, fail_cnt=0.
//   OPEN: timer counts UNLOCK_CYCLES, then -> ENTRY.
//     - 0xE: immediate relock -> ENTRY.
//     - 0xA: -> PROGRAM, buffer cleared.
//     - Other keys: ignored.
//     - Expiry and a key in the same cycle: expiry wins.
//   PROGRAM: no timeout.
//     - Digit entry as in ENTRY.
//     - 0xF with count==CODE_LEN: code<=buffer, -> ENTRY (locked).
//     - 0xF with count<CODE_LEN: ignored.
//     - 0xE: abort -> ENTRY, code unchanged.
//   Every transition into ENTRY clears the buffer and count.
//   Timers reload on state entry. Counter widths are $clog2(limit+1).
//   Comparison is over exactly CODE_LEN nibbles.
//   Outputs are registered or decoded from the state register only. No input-to-output
//   combinational path.
// TESTING
//   1. Reset, keys 1,2,3,4,F: unlocked=1 one cycle after F.
//      Falls exactly 500 cycles later. disp_key=0xF.
//   2. Keys 1,2,3,5,F, three times: error pulses 3x and locked_out=1.
//      Keys 1,2,3,4,F during lockout: no effect. After 1000 cycles, state is ENTRY
//      and correct code unlocks.
//   3. Keys 1,2,E,1,2,3,4,F: clear resets count to 0, then unlock.
//      Keys 1,2,F: error pulse, count 0.
//   4. Unlock, press A, then 9,8,7,6,F: prog_mode then locked.
//      9876F unlocks and 1234F errors.
//      Assert rst_n low: code reverts, 1234F unlocks.
//   5. Unlock, then 0xE at cycle 10: relock.
//      In PROGRAM, 5,E: code unchanged.
//      key toggled with key_valid=0: no state change.

Source files
------------

// File: rtl/keypad_if.sv
// Key-in / status-out bundle between the keypad scanner side and the code lock.
// The master drives key strobes; the slave (the lock) drives status and display.
interface keypad_if #(
    parameter int CODE_LEN = 4
);
    localparam int CW = $clog2(CODE_LEN + 1);

    logic [3:0]    key;
    logic          key_valid;
    logic          unlocked;
    logic          prog_mode;
    logic          error;
    logic          locked_out;
    logic [CW-1:0] digit_count;
    logic [3:0]    disp_key;

    modport master (
        output key, key_valid,
        input  unlocked, prog_mode, error, locked_out, digit_count, disp_key
    );

    modport slave (
        input  key, key_valid,
        output unlocked, prog_mode, error, locked_out, digit_count, disp_key
    );
endinterface

// File: rtl/keypad_code_lock.sv
// Digit-code lock: buffers keypad digits, checks them against a stored code,
// and manages open / failed-attempt / lockout / reprogramming states.
module keypad_code_lock #(
    parameter int          CODE_LEN       = 4,
    parameter logic [31:0] DEFAULT_CODE   = 32'h1234,
    parameter int          MAX_FAILS      = 3,
    parameter int          UNLOCK_CYCLES  = 500,
    parameter int          LOCKOUT_CYCLES = 1000
) (
    input  logic   clk,
    input  logic   rst_n,
    keypad_if.slave kp
);
    localparam int CW   = $clog2(CODE_LEN + 1);
    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = 4 * CODE_LEN;

    localparam logic [3:0] KEY_PROG  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic [2:0] {
        S_ENTRY, S_FAIL, S_OPEN, S_PROGRAM, S_LOCKOUT
    } state_t;

    state_t        state_reg, state_next;
    logic [BW-1:0] buf_reg,   buf_next;
    logic [BW-1:0] code_reg,  code_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic [FW-1:0] fail_reg,  fail_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [3:0]    disp_reg,  disp_next;

    logic          is_digit;
    logic          full;
    logic [BW+3:0] shifted;

    assign is_digit = (kp.key <= 4'd9);
    assign full     = (cnt_reg == CW'(CODE_LEN));
    // Concatenate then truncate so the shift also works for a single-digit code.
    assign shifted  = {buf_reg, kp.key};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_ENTRY;
            buf_reg   <= '0;
            code_reg  <= DEFAULT_CODE[BW-1:0];
            cnt_reg   <= '0;
            fail_reg  <= '0;
            timer_reg <= '0;
            disp_reg  <= '0;
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            code_reg  <= code_next;
            cnt_reg   <= cnt_next;
            fail_reg  <= fail_next;
            timer_reg <= timer_next;
            disp_reg  <= disp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        buf_next   = buf_reg;
        code_next  = code_reg;
        cnt_next   = cnt_reg;
        fail_next  = fail_reg;
        disp_next  = disp_reg;

        unique case (state_reg)
            S_ENTRY, S_PROGRAM: begin
                if (kp.key_valid) begin
                    if (is_digit) begin
                        if (!full) begin
                            buf_next  = shifted[BW-1:0];
                            cnt_next  = cnt_reg + CW'(1);
                            disp_next = kp.key;
                        end
                    end else if (kp.key == KEY_CLEAR) begin
                        disp_next = kp.key;
                        buf_next  = '0;
                        cnt_next  = '0;
                        state_next = S_ENTRY;
                    end else if (kp.key == KEY_ENTER) begin
                        if (state_reg == S_ENTRY) begin
                            disp_next = kp.key;
                            if (full && (buf_reg == code_reg)) begin
                                state_next = S_OPEN;
                                fail_next  = '0;
                            end else begin
                                state_next = S_FAIL;
                            end
                        end else if (full) begin
                            disp_next  = kp.key;
                            code_next  = buf_reg;
                            state_next = S_ENTRY;
                        end
                    end
                end
            end
            S_FAIL: begin
                fail_next  = fail_reg + FW'(1);
                state_next = ((fail_reg + FW'(1)) == FW'(MAX_FAILS)) ? S_LOCKOUT : S_ENTRY;
            end
            S_LOCKOUT: begin
                if (timer_reg == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_next = S_ENTRY;
                    fail_next  = '0;
                end
            end
            S_OPEN: begin
                // Timeout takes priority over any key arriving in the same cycle.
                if (timer_reg == TW'(UNLOCK_CYCLES - 1)) begin
                    state_next = S_ENTRY;
                end else if (kp.key_valid && (kp.key == KEY_CLEAR)) begin
                    disp_next  = kp.key;
                    state_next = S_ENTRY;
                end else if (kp.key_valid && (kp.key == KEY_PROG)) begin
                    disp_next  = kp.key;
                    state_next = S_PROGRAM;
                end
            end
            default: state_next = S_ENTRY;
        endcase

        // Any state change starts from an empty buffer and a fresh timer,
        // so a matched code is never left sitting in the buffer while open.
        if (state_next != state_reg) begin
            buf_next   = '0;
            cnt_next   = '0;
            timer_next = '0;
        end else if ((state_reg == S_OPEN) || (state_reg == S_LOCKOUT)) begin
            timer_next = timer_reg + TW'(1);
        end else begin
            timer_next = timer_reg;
        end
    end

    assign kp.unlocked    = (state_reg == S_OPEN);
    assign kp.prog_mode   = (state_reg == S_PROGRAM);
    assign kp.error       = (state_reg == S_FAIL);
    assign kp.locked_out  = (state_reg == S_LOCKOUT);
    assign kp.digit_count = cnt_reg;
    assign kp.disp_key    = disp_reg;
endmodule

// File: tb/tb_keypad_code_lock.sv
// Bench for keypad_code_lock: a key-sequence reference model checked every cycle,
// a table of hand-derived vectors, directed corner sequences and random keys.
module tb_keypad_code_lock;
    localparam int          LEN     = 4;
    localparam logic [31:0] DEF     = 32'h1234;
    localparam int          MAXF    = 3;
    localparam int          UNLOCK  = 500;
    localparam int          LOCKOUT = 1000;

    localparam int M_ENTRY = 0, M_FAIL = 1, M_OPEN = 2, M_PROG = 3, M_LOCK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_if #(.CODE_LEN(LEN)) kp ();

    keypad_code_lock #(
        .CODE_LEN(LEN), .DEFAULT_CODE(DEF), .MAX_FAILS(MAXF),
        .UNLOCK_CYCLES(UNLOCK), .LOCKOUT_CYCLES(LOCKOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: digits held as a queue, code as a digit array,
    // timers as "cycles remaining" countdowns.
    int m_mode, m_fails, m_rem, m_disp;
    int m_dig[$];
    int m_code[LEN];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_enter(input int m);
        m_mode = m;
        m_dig.delete();
        if (m == M_OPEN) m_rem = UNLOCK;
        if (m == M_LOCK) m_rem = LOCKOUT;
    endtask

    function automatic bit m_match();
        if (m_dig.size() != LEN) return 1'b0;
        for (int i = 0; i < LEN; i++)
            if (m_dig[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LEN; i++) m_code[i] = int'((DEF >> (4 * (LEN - 1 - i))) & 32'hF);
        m_fails = 0;
        m_rem   = 0;
        m_disp  = 0;
        m_enter(M_ENTRY);
    endtask

    task automatic model_step(input int k, input bit v);
        case (m_mode)
            M_ENTRY, M_PROG: if (v) begin
                if (k <= 9) begin
                    if (m_dig.size() < LEN) begin
                        m_dig.push_back(k);
                        m_disp = k;
                    end
                end else if (k == 14) begin
                    m_disp = k;
                    m_enter(M_ENTRY);
                end else if (k == 15) begin
                    if (m_mode == M_ENTRY) begin
                        m_disp = k;
                        if (m_match()) begin
                            m_fails = 0;
                            m_enter(M_OPEN);
                        end else begin
                            m_enter(M_FAIL);
                        end
                    end else if (m_dig.size() == LEN) begin
                        m_disp = k;
                        for (int i = 0; i < LEN; i++) m_code[i] = m_dig[i];
                        m_enter(M_ENTRY);
                    end
                end
            end
            M_FAIL: begin
                m_fails++;
                m_enter((m_fails == MAXF) ? M_LOCK : M_ENTRY);
            end
            M_LOCK: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_fails = 0;
                    m_enter(M_ENTRY);
                end
            end
            M_OPEN: begin
                m_rem--;
                if (m_rem == 0) m_enter(M_ENTRY);
                else if (v && k == 14) begin
                    m_disp = k;
                    m_enter(M_ENTRY);
                end else if (v && k == 10) begin
                    m_disp = k;
                    m_enter(M_PROG);
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        chk("unlocked",    int'(kp.unlocked),    int'(m_mode == M_OPEN));
        chk("prog_mode",   int'(kp.prog_mode),   int'(m_mode == M_PROG));
        chk("error",       int'(kp.error),       int'(m_mode == M_FAIL));
        chk("locked_out",  int'(kp.locked_out),  int'(m_mode == M_LOCK));
        chk("digit_count", int'(kp.digit_count), m_dig.size());
        chk("disp_key",    int'(kp.disp_key),    m_disp);
    endtask

    task automatic tick(input logic [3:0] k, input logic v);
        kp.key       = k;
        kp.key_valid = v;
        @(posedge clk);
        model_step(int'(k), v);
        #1;
        check_model();
    endtask

    task automatic press(input int k);
        tick(4'(k), 1'b1);
    endtask

    task automatic idle();
        tick(4'h0, 1'b0);
    endtask

    task automatic press_code(input logic [31:0] c);
        for (int i = LEN - 1; i >= 0; i--) press(int'((c >> (4 * i)) & 32'hF));
    endtask

    task automatic do_reset();
        kp.key_valid = 1'b0;
        kp.key       = 4'h0;
        rst_n        = 1'b0;
        #3;
        model_reset();
        check_model();
        @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] key;
        logic       valid;
        logic       unl;
        logic       err;
        int         cnt;
        logic [3:0] disp;
    } vec_t;

    vec_t vecs[17];
    int   n_err, n_lock, t_open;

    initial begin
        kp.key       = 4'h0;
        kp.key_valid = 1'b0;

        // Expected outputs after each key, from reset.
        vecs[0]  = '{4'h1, 1'b1, 1'b0, 1'b0, 1, 4'h1};
        vecs[1]  = '{4'h2, 1'b1, 1'b0, 1'b0, 2, 4'h2};
        vecs[2]  = '{4'hE, 1'b1, 1'b0, 1'b0, 0, 4'hE};
        vecs[3]  = '{4'h1, 1'b1, 1'b0, 1'b0, 1, 4'h1};
        vecs[4]  = '{4'h2, 1'b1, 1'b0, 1'b0, 2, 4'h2};
        vecs[5]  = '{4'h3, 1'b1, 1'b0, 1'b0, 3, 4'h3};
        vecs[6]  = '{4'h4, 1'b1, 1'b0, 1'b0, 4, 4'h4};
        vecs[7]  = '{4'h7, 1'b0, 1'b0, 1'b0, 4, 4'h4};
        vecs[8]  = '{4'hB, 1'b1, 1'b0, 1'b0, 4, 4'h4};
        vecs[9]  = '{4'h5, 1'b1, 1'b0, 1'b0, 4, 4'h4};
        vecs[10] = '{4'hF, 1'b1, 1'b1, 1'b0, 0, 4'hF};
        vecs[11] = '{4'h1, 1'b1, 1'b1, 1'b0, 0, 4'hF};
        vecs[12] = '{4'hE, 1'b1, 1'b0, 1'b0, 0, 4'hE};
        vecs[13] = '{4'h1, 1'b1, 1'b0, 1'b0, 1, 4'h1};
        vecs[14] = '{4'h2, 1'b1, 1'b0, 1'b0, 2, 4'h2};
        vecs[15] = '{4'hF, 1'b1, 1'b0, 1'b1, 0, 4'hF};
        vecs[16] = '{4'h0, 1'b0, 1'b0, 1'b0, 0, 4'hF};

        do_reset();
        chk("reset_disp", int'(kp.disp_key), 0);
        chk("reset_count", int'(kp.digit_count), 0);

        for (int i = 0; i < 17; i++) begin
            tick(vecs[i].key, vecs[i].valid);
            $display("vec %0d: key=%h valid=%0d -> unlocked=%0d error=%0d count=%0d disp=%h",
                     i, vecs[i].key, vecs[i].valid, kp.unlocked, kp.error, kp.digit_count, kp.disp_key);
            chk($sformatf("vec%0d_unlocked", i), int'(kp.unlocked), int'(vecs[i].unl));
            chk($sformatf("vec%0d_error", i),    int'(kp.error),    int'(vecs[i].err));
            chk($sformatf("vec%0d_count", i),    int'(kp.digit_count), vecs[i].cnt);
            chk($sformatf("vec%0d_disp", i),     int'(kp.disp_key), int'(vecs[i].disp));
        end

        // Unlock window is exactly UNLOCK cycles; a key on the final cycle loses to expiry.
        do_reset();
        press_code(DEF);
        press(15);
        chk("t1_unlock_rise", int'(kp.unlocked), 1);
        for (int i = 0; i < UNLOCK - 1; i++) idle();
        chk("t1_still_open", int'(kp.unlocked), 1);
        press(10);
        chk("t1_expired", int'(kp.unlocked), 0);
        chk("t1_expiry_wins", int'(kp.prog_mode), 0);
        chk("t1_disp", int'(kp.disp_key), 15);
        $display("seq unlock-timeout done");

        // Three wrong codes -> lockout lasting LOCKOUT cycles, keys ignored meanwhile.
        do_reset();
        n_err = 0;
        for (int a = 0; a < MAXF; a++) begin
            press_code(32'h1235);
            press(15);
            n_err += int'(kp.error);
            idle();
        end
        chk("t2_error_pulses", n_err, MAXF);
        chk("t2_locked_out", int'(kp.locked_out), 1);
        n_lock = 1;
        press_code(DEF);
        press(15);
        n_lock += 5;
        chk("t2_keys_ignored", int'(kp.disp_key), 15);
        chk("t2_count_ignored", int'(kp.digit_count), 0);
        for (int i = 0; i < LOCKOUT + 100; i++) begin
            idle();
            if (!kp.locked_out) break;
            n_lock++;
        end
        chk("t2_lockout_len", n_lock, LOCKOUT);
        press_code(DEF);
        press(15);
        chk("t2_unlock_after", int'(kp.unlocked), 1);
        $display("seq lockout done");

        // Reprogramming, then reset restores the default code.
        do_reset();
        press_code(DEF); press(15);
        press(10);
        chk("t4_prog_mode", int'(kp.prog_mode), 1);
        press_code(32'h9876); press(15);
        chk("t4_locked", int'(kp.unlocked), 0);
        chk("t4_prog_exit", int'(kp.prog_mode), 0);
        press_code(32'h9876); press(15);
        chk("t4_new_code", int'(kp.unlocked), 1);
        press(14);
        press_code(DEF); press(15);
        chk("t4_old_code_err", int'(kp.error), 1);
        idle();
        do_reset();
        press_code(DEF); press(15);
        chk("t4_reset_code", int'(kp.unlocked), 1);
        $display("seq program/reset done");

        // Manual relock, program abort, and keys without key_valid.
        do_reset();
        press_code(DEF); press(15);
        for (int i = 0; i < 9; i++) idle();
        press(14);
        chk("t5_relock", int'(kp.unlocked), 0);
        press_code(DEF); press(15);
        press(10); press(5); press(14);
        chk("t5_abort", int'(kp.prog_mode), 0);
        press_code(DEF); press(15);
        chk("t5_code_kept", int'(kp.unlocked), 1);
        t_open = 0;
        for (int i = 0; i < 8; i++) begin
            tick(4'(i * 3 + 1), 1'b0);
            t_open += int'(kp.unlocked);
        end
        chk("t5_novalid", t_open, 8);
        chk("t5_novalid_disp", int'(kp.disp_key), 15);
        $display("seq relock/abort done");

        // Random keys against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            int r, k;
            r = int'($urandom_range(0, 15));
            if (r < 10)       k = int'($urandom_range(1, 4));
            else if (r < 12)  k = 15;
            else if (r == 12) k = 10;
            else if (r == 13) k = 14;
            else              k = int'($urandom_range(0, 15));
            tick(4'(k), 1'($urandom_range(0, 9) < 6));
        end
        $display("random phase done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
